// File: rtl/calc_op_sequencer.sv
// rtl/calc_op_sequencer.sv - calculator accumulator sequencer: single-cycle add/sub, iterative mul/div
module calc_op_sequencer #(
    parameter int ACC_W = 16,
    parameter int OPD_W = 7
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             op_add,
    input  logic             op_sub,
    input  logic             op_mul,
    input  logic             op_div,
    input  logic             op_clr,
    input  logic [OPD_W-1:0] operand,
    output logic [ACC_W-1:0] acc,
    output logic             busy,
    output logic             done,
    output logic             ovf,
    output logic             err
);
    localparam int PRD_W = ACC_W + OPD_W;
    localparam int CNT_W = $clog2(ACC_W > OPD_W ? ACC_W : OPD_W);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2
    } state_t;

    state_t state, state_next;

    logic [CNT_W-1:0] cnt;
    logic [ACC_W-1:0] mcand;
    logic [OPD_W-1:0] mplier;
    logic [PRD_W-1:0] product;
    logic [ACC_W-1:0] quo;
    logic [OPD_W-1:0] rem;
    logic [OPD_W-1:0] divisor;

    logic             do_add, do_sub, do_mul, do_div, do_clr;
    logic             last_mul, last_div;
    logic [ACC_W:0]   add_sum;
    logic [ACC_W-1:0] sub_diff;
    logic             borrow;
    logic [PRD_W-1:0] prod_next;
    logic [OPD_W:0]   trial;
    logic             trial_ge;
    logic [OPD_W-1:0] rem_next;
    logic [ACC_W-1:0] quo_next;

    // Fixed accept priority: add > sub > mul > div > clr.
    always_comb begin
        do_add = op_add;
        do_sub = !op_add && op_sub;
        do_mul = !op_add && !op_sub && op_mul;
        do_div = !op_add && !op_sub && !op_mul && op_div;
        do_clr = !op_add && !op_sub && !op_mul && !op_div && op_clr;
    end

    assign last_mul = (cnt == CNT_W'(OPD_W - 1));
    assign last_div = (cnt == CNT_W'(ACC_W - 1));
    assign busy     = (state != IDLE);

    assign add_sum  = (ACC_W+1)'(acc) + (ACC_W+1)'(operand);
    assign sub_diff = acc - ACC_W'(operand);
    assign borrow   = (ACC_W'(operand) > acc);

    // Shift-add step: multiplicand weighted by the current bit position.
    assign prod_next = mplier[0] ? (product + (PRD_W'(mcand) << cnt)) : product;

    // Restoring-divide step; the partial remainder stays below the divisor so OPD_W bits suffice.
    assign trial    = {rem, quo[ACC_W-1]};
    assign trial_ge = (trial >= (OPD_W+1)'(divisor));
    always_comb begin
        rem_next = trial[OPD_W-1:0];
        if (trial_ge) begin
            rem_next = OPD_W'(trial - (OPD_W+1)'(divisor));
        end
    end
    assign quo_next = {quo[ACC_W-2:0], trial_ge};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (do_mul) begin
                    state_next = MUL;
                end else if (do_div && (operand != '0)) begin
                    state_next = DIV;
                end
            end
            MUL: begin
                if (op_clr || last_mul) begin
                    state_next = IDLE;
                end
            end
            DIV: begin
                if (op_clr || last_div) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc     <= '0;
            done    <= 1'b0;
            ovf     <= 1'b0;
            err     <= 1'b0;
            cnt     <= '0;
            mcand   <= '0;
            mplier  <= '0;
            product <= '0;
            quo     <= '0;
            rem     <= '0;
            divisor <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (do_add) begin
                        acc  <= add_sum[ACC_W-1:0];
                        ovf  <= add_sum[ACC_W];
                        done <= 1'b1;
                    end else if (do_sub) begin
                        acc  <= sub_diff;
                        ovf  <= borrow;
                        done <= 1'b1;
                    end else if (do_mul) begin
                        mcand   <= acc;
                        mplier  <= operand;
                        product <= '0;
                        cnt     <= '0;
                        ovf     <= 1'b0;
                    end else if (do_div) begin
                        ovf <= 1'b0;
                        if (operand == '0) begin
                            err  <= 1'b1;
                            done <= 1'b1;
                        end else begin
                            quo     <= acc;
                            rem     <= '0;
                            divisor <= operand;
                            cnt     <= '0;
                        end
                    end else if (do_clr) begin
                        acc <= '0;
                        err <= 1'b0;
                        ovf <= 1'b0;
                    end
                end
                MUL: begin
                    if (op_clr) begin
                        acc <= '0;
                        err <= 1'b0;
                        ovf <= 1'b0;
                    end else begin
                        product <= prod_next;
                        mplier  <= mplier >> 1;
                        cnt     <= cnt + 1'b1;
                        if (last_mul) begin
                            acc  <= prod_next[ACC_W-1:0];
                            ovf  <= |prod_next[PRD_W-1:ACC_W];
                            done <= 1'b1;
                        end
                    end
                end
                DIV: begin
                    if (op_clr) begin
                        acc <= '0;
                        err <= 1'b0;
                        ovf <= 1'b0;
                    end else begin
                        quo <= quo_next;
                        rem <= rem_next;
                        cnt <= cnt + 1'b1;
                        if (last_div) begin
                            acc  <= quo_next;
                            done <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_calc_op_sequencer.sv
// tb/tb_calc_op_sequencer.sv - directed self-checking bench for calc_op_sequencer
module tb_calc_op_sequencer;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        op_add, op_sub, op_mul, op_div, op_clr;
    logic [6:0]  operand;
    logic [15:0] acc;
    logic        busy, done, ovf, err;

    int errors = 0;
    int checks = 0;

    calc_op_sequencer #(.ACC_W(16), .OPD_W(7)) dut (
        .clk(clk), .rst_n(rst_n),
        .op_add(op_add), .op_sub(op_sub), .op_mul(op_mul), .op_div(op_div), .op_clr(op_clr),
        .operand(operand),
        .acc(acc), .busy(busy), .done(done), .ovf(ovf), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge right after the accept edge.
    task automatic pulse(input logic a, input logic s, input logic m, input logic d,
                         input logic c, input logic [6:0] opd);
        op_add = a; op_sub = s; op_mul = m; op_div = d; op_clr = c; operand = opd;
        @(negedge clk);
        op_add = 0; op_sub = 0; op_mul = 0; op_div = 0; op_clr = 0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy === 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_idle"}, {15'd0, busy}, 16'd0);
        chk({tag, "_done"}, {15'd0, done}, 16'd1);
    endtask

    initial begin
        logic saw_done;
        logic saw_busy;
        rst_n = 0;
        op_add = 0; op_sub = 0; op_mul = 0; op_div = 0; op_clr = 0; operand = '0;
        repeat (3) @(negedge clk);
        chk("rst_acc", acc, 16'd0);
        chk("rst_busy", {15'd0, busy}, 16'd0);
        chk("rst_done", {15'd0, done}, 16'd0);
        chk("rst_ovf", {15'd0, ovf}, 16'd0);
        chk("rst_err", {15'd0, err}, 16'd0);
        rst_n = 1;
        @(negedge clk);

        // 1: two adds of 5
        saw_busy = 0;
        pulse(1, 0, 0, 0, 0, 7'd5);
        chk("add1_acc", acc, 16'd5);
        chk("add1_done", {15'd0, done}, 16'd1);
        saw_busy |= busy;
        @(negedge clk);
        chk("add1_done_drop", {15'd0, done}, 16'd0);
        pulse(1, 0, 0, 0, 0, 7'd5);
        saw_busy |= busy;
        chk("add2_acc", acc, 16'd10);
        chk("add2_done", {15'd0, done}, 16'd1);
        chk("add2_ovf", {15'd0, ovf}, 16'd0);
        chk("add_busy", {15'd0, saw_busy}, 16'd0);

        // 2: borrow then carry
        pulse(0, 0, 0, 0, 1, 7'd0);
        chk("clr_done", {15'd0, done}, 16'd0);
        pulse(1, 0, 0, 0, 0, 7'd2);
        pulse(0, 1, 0, 0, 0, 7'd3);
        chk("sub_acc", acc, 16'hFFFF);
        chk("sub_ovf", {15'd0, ovf}, 16'd1);
        pulse(1, 0, 0, 0, 0, 7'd1);
        chk("carry_acc", acc, 16'h0000);
        chk("carry_ovf", {15'd0, ovf}, 16'd1);

        // 3: 300 * 7 with an ignored add and operand change while busy
        pulse(0, 0, 0, 0, 1, 7'd0);
        repeat (3) pulse(1, 0, 0, 0, 0, 7'd100);
        chk("pre_mul_acc", acc, 16'd300);
        pulse(0, 0, 1, 0, 0, 7'd7);
        for (int i = 0; i < 7; i++) begin
            chk($sformatf("mul_busy%0d", i), {15'd0, busy}, 16'd1);
            chk($sformatf("mul_nodone%0d", i), {15'd0, done}, 16'd0);
            if (i == 2) begin op_add = 1; operand = 7'd99; end
            if (i == 3) op_add = 0;
            @(negedge clk);
        end
        chk("mul_acc", acc, 16'd2100);
        chk("mul_busy_end", {15'd0, busy}, 16'd0);
        chk("mul_done", {15'd0, done}, 16'd1);
        chk("mul_ovf", {15'd0, ovf}, 16'd0);
        @(negedge clk);
        chk("mul_done_drop", {15'd0, done}, 16'd0);
        chk("mul_hold", acc, 16'd2100);

        // 4: 2100 / 7, then divide by zero, then clear
        pulse(0, 0, 0, 1, 0, 7'd7);
        operand = 7'd1;
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("div_busy%0d", i), {15'd0, busy}, 16'd1);
            @(negedge clk);
        end
        chk("div_acc", acc, 16'd300);
        chk("div_busy_end", {15'd0, busy}, 16'd0);
        chk("div_done", {15'd0, done}, 16'd1);
        @(negedge clk);
        pulse(0, 0, 0, 1, 0, 7'd0);
        chk("div0_acc", acc, 16'd300);
        chk("div0_err", {15'd0, err}, 16'd1);
        chk("div0_busy", {15'd0, busy}, 16'd0);
        chk("div0_done", {15'd0, done}, 16'd1);
        @(negedge clk);
        chk("div0_done_once", {15'd0, done}, 16'd0);
        chk("err_sticky", {15'd0, err}, 16'd1);
        pulse(0, 0, 0, 0, 1, 7'd0);
        chk("clr_acc", acc, 16'd0);
        chk("clr_err", {15'd0, err}, 16'd0);

        // 5: add wins over mul; clr aborts a running mul
        pulse(1, 0, 0, 0, 0, 7'd1);
        pulse(1, 0, 1, 0, 0, 7'd4);
        chk("prio_acc", acc, 16'd5);
        chk("prio_busy", {15'd0, busy}, 16'd0);
        chk("prio_done", {15'd0, done}, 16'd1);
        @(negedge clk);
        pulse(0, 0, 1, 0, 0, 7'd3);
        chk("abort_busy_start", {15'd0, busy}, 16'd1);
        @(negedge clk);
        pulse(0, 0, 0, 0, 1, 7'd0);
        chk("abort_acc", acc, 16'd0);
        chk("abort_busy", {15'd0, busy}, 16'd0);
        saw_done = 0;
        for (int i = 0; i < 10; i++) begin
            saw_done |= done;
            @(negedge clk);
        end
        chk("abort_nodone", {15'd0, saw_done}, 16'd0);

        // 6: 1*64*64*8 = 0x8000, then *4 overflows to 0
        pulse(1, 0, 0, 0, 0, 7'd1);
        pulse(0, 0, 1, 0, 0, 7'd64);
        wait_idle("m64a");
        chk("m64a_acc", acc, 16'd64);
        pulse(0, 0, 1, 0, 0, 7'd64);
        wait_idle("m64b");
        chk("m64b_acc", acc, 16'd4096);
        pulse(0, 0, 1, 0, 0, 7'd8);
        wait_idle("m8");
        chk("m8_acc", acc, 16'h8000);
        chk("m8_ovf", {15'd0, ovf}, 16'd0);
        pulse(0, 0, 1, 0, 0, 7'd4);
        wait_idle("m4");
        chk("ovf_acc", acc, 16'h0000);
        chk("ovf_flag", {15'd0, ovf}, 16'd1);

        // Reset in the middle of a divide
        pulse(1, 0, 0, 0, 0, 7'd100);
        chk("ovf_cleared", {15'd0, ovf}, 16'd0);
        pulse(0, 0, 0, 1, 0, 7'd3);
        repeat (5) @(negedge clk);
        chk("rst_div_running", {15'd0, busy}, 16'd1);
        #2 rst_n = 0;
        #1;
        chk("rst_div_acc", acc, 16'd0);
        chk("rst_div_busy", {15'd0, busy}, 16'd0);
        @(negedge clk);
        rst_n = 1;
        saw_done = 0;
        saw_busy = 0;
        for (int i = 0; i < 20; i++) begin
            saw_done |= done;
            saw_busy |= busy;
            @(negedge clk);
        end
        chk("rst_div_nodone", {15'd0, saw_done}, 16'd0);
        chk("rst_div_nobusy", {15'd0, saw_busy}, 16'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
